// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - shared state encoding and parameter legality for led_fader
//
// Purpose : FSM state type used by the fader top, plus a constant function
//           that the top evaluates at elaboration to reject illegal parameters.
// Ports   : none (package)

package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fader_state_t;

    localparam int PWM_BITS_MIN    = 2;
    localparam int PWM_BITS_MAX    = 16;
    localparam int STEP_CYCLES_MIN = 1;

    function automatic bit params_ok(input int pb, input int sc);
        return (pb >= PWM_BITS_MIN) && (pb <= PWM_BITS_MAX) && (sc >= STEP_CYCLES_MIN);
    endfunction

endpackage

// File: rtl/led_fader_pwm_gen.sv
// rtl/led_fader_pwm_gen.sv - free-running PWM counter with registered compare
//
// Purpose : turns a brightness level into a PWM waveform whose period is
//           2^pwm_bits cycles and whose high time is `level` cycles.
// Ports   : clk    in   system clock
//           rst_n  in   asynchronous active-low reset
//           level  in   brightness 0..MAX
//           q      out  PWM output, one cycle behind level/counter

module pwm_gen
    import led_fader_pkg::*;
#(
    parameter int pwm_bits = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [pwm_bits-1:0] level,
    output logic                q
);

    localparam logic [pwm_bits-1:0] MAX_LVL = {pwm_bits{1'b1}};

    logic [pwm_bits-1:0] r_pwm_cnt;
    logic                r_q;
    logic                w_q_nxt;

    // Full brightness would otherwise drop for the one count equal to MAX,
    // so the two extremes are forced to constant levels.
    always_comb begin
        if (level == '0) begin
            w_q_nxt = 1'b0;
        end else if (level == MAX_LVL) begin
            w_q_nxt = 1'b1;
        end else begin
            w_q_nxt = (r_pwm_cnt < level);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_q       <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + pwm_bits'(1);
            r_q       <= w_q_nxt;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED fader ramping brightness on blink edges
//
// Purpose : registers the raw blink, runs an OFF/RISE/ON/FALL FSM that steps
//           the brightness by one level every step_cycles clocks, and drives
//           the LED through pwm_gen.
// Ports   : clk    in   system clock
//           rst_n  in   asynchronous active-low reset
//           blink  in   raw blink from the SoC
//           q      out  PWM LED drive
//           level  out  current brightness 0..MAX
//           busy   out  high while ramping (RISE or FALL)

module led_fader
    import led_fader_pkg::*;
#(
    parameter int pwm_bits    = 4,
    parameter int step_cycles = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blink,
    output logic                q,
    output logic [pwm_bits-1:0] level,
    output logic                busy
);

    if (!params_ok(pwm_bits, step_cycles)) begin : g_bad_params
        $error("led_fader: pwm_bits must be 2..16 and step_cycles >= 1");
    end

    localparam int                  SW        = (step_cycles > 1) ? $clog2(step_cycles) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(step_cycles - 1);
    localparam logic [pwm_bits-1:0] MAX_LVL   = {pwm_bits{1'b1}};
    localparam logic [pwm_bits-1:0] ZERO_LVL  = '0;

    fader_state_t        r_state;
    fader_state_t        w_state_nxt;
    logic                r_blink;
    logic [pwm_bits-1:0] r_level;
    logic [pwm_bits-1:0] w_level_nxt;
    logic [SW-1:0]       r_step_cnt;
    logic [SW-1:0]       w_step_nxt;
    logic                r_busy;
    logic                w_step_done;
    logic [pwm_bits-1:0] w_lvl_up;
    logic [pwm_bits-1:0] w_lvl_dn;

    // Saturating neighbours: a reversal taken before the first step can leave
    // RISE at MAX or FALL at 0, so the step itself must not wrap.
    assign w_lvl_up    = (r_level == MAX_LVL)  ? MAX_LVL  : r_level + pwm_bits'(1);
    assign w_lvl_dn    = (r_level == ZERO_LVL) ? ZERO_LVL : r_level - pwm_bits'(1);
    assign w_step_done = (r_step_cnt == STEP_LAST);

    // step counter defaults to 0, which covers both the hold in OFF/ON and the
    // clear on every entry into RISE/FALL (including reversals).
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_step_nxt  = '0;
        case (r_state)
            ST_OFF: begin
                if (r_blink) begin
                    w_state_nxt = ST_RISE;
                end
            end
            ST_RISE: begin
                if (!r_blink) begin
                    w_state_nxt = ST_FALL;
                end else if (w_step_done) begin
                    w_level_nxt = w_lvl_up;
                    if (w_lvl_up == MAX_LVL) begin
                        w_state_nxt = ST_ON;
                    end
                end else begin
                    w_step_nxt = r_step_cnt + SW'(1);
                end
            end
            ST_ON: begin
                if (!r_blink) begin
                    w_state_nxt = ST_FALL;
                end
            end
            ST_FALL: begin
                if (r_blink) begin
                    w_state_nxt = ST_RISE;
                end else if (w_step_done) begin
                    w_level_nxt = w_lvl_dn;
                    if (w_lvl_dn == ZERO_LVL) begin
                        w_state_nxt = ST_OFF;
                    end
                end else begin
                    w_step_nxt = r_step_cnt + SW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_level_nxt = ZERO_LVL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_blink    <= 1'b0;
            r_level    <= '0;
            r_step_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_blink    <= blink;
            r_level    <= w_level_nxt;
            r_step_cnt <= w_step_nxt;
            r_busy     <= (w_state_nxt == ST_RISE) || (w_state_nxt == ST_FALL);
        end
    end

    pwm_gen #(
        .pwm_bits (pwm_bits)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .level (r_level),
        .q     (q)
    );

    assign level = r_level;
    assign busy  = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - self-checking bench for led_fader

module tb_led_fader;

    localparam int MAXV = 15;
    localparam int SC   = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       blink = 1'b0;
    logic       q;
    logic [3:0] level;
    logic       busy;

    logic       rst2_n = 1'b0;
    logic       blink2 = 1'b0;
    logic       q2;
    logic [1:0] level2;
    logic       busy2;

    int n_err    = 0;
    int n_checks = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    led_fader #(.pwm_bits(4), .step_cycles(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .blink (blink),
        .q     (q),
        .level (level),
        .busy  (busy)
    );

    led_fader #(.pwm_bits(2), .step_cycles(1)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .blink (blink2),
        .q     (q2),
        .level (level2),
        .busy  (busy2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: brightness moves one level toward the registered blink every
    // SC cycles of uninterrupted travel; a change of direction restarts the
    // interval; travel ends on reaching 0 or MAX. PWM high while phase < level.
    int m_level = 0;
    int m_dir   = 0;
    int m_t     = 0;
    int m_ph    = 0;
    bit m_br    = 0;
    bit m_q     = 0;

    always @(posedge clk or negedge rst_n) begin
        bit prev_br;
        int want;
        if (!rst_n) begin
            m_level = 0; m_dir = 0; m_t = 0; m_ph = 0; m_br = 0; m_q = 0;
        end else begin
            prev_br = m_br;
            m_br    = blink;
            m_q     = (m_level == MAXV) || (m_ph < m_level);
            m_ph    = (m_ph + 1) % (MAXV + 1);
            if (m_dir == 0) begin
                if (m_level == 0 && prev_br) begin
                    m_dir = 1; m_t = 0;
                end else if (m_level == MAXV && !prev_br) begin
                    m_dir = -1; m_t = 0;
                end
            end else begin
                want = prev_br ? 1 : -1;
                if (want != m_dir) begin
                    m_dir = want; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == SC) begin
                        m_t = 0;
                        m_level += m_dir;
                        if (m_level > MAXV) m_level = MAXV;
                        if (m_level < 0) m_level = 0;
                        if ((m_dir > 0 && m_level == MAXV) || (m_dir < 0 && m_level == 0))
                            m_dir = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_level", int'(level), m_level);
            check("model_busy", int'(busy), (m_dir != 0) ? 1 : 0);
            check("model_q", int'(q), int'(m_q));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int hi;
        int peak;
        bit all_ok;

        // reset held with blink high
        blink = 1'b1;
        cyc();
        chk_en = 1;
        cyc(); cyc();
        check("rst_q", int'(q), 0);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);

        rst_n = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!busy && n < 20);
        check("busy_after_release_edges", n, 2);
        n = 0;
        do begin cyc(); n++; end while (level != 4'd1 && n < 40);
        check("first_step_edges", n, 16);
        do begin cyc(); n++; end while (level != 4'd15 && n < 400);
        check("full_rise_edges", n, 240);
        check("full_rise_busy_low", int'(busy), 0);
        all_ok = 1;
        for (int i = 0; i < 16; i++) begin cyc(); if (q !== 1'b1) all_ok = 0; end
        check("on_q_const_high", int'(all_ok), 1);

        // full fall
        blink = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (level != 4'd0 && n < 400);
        check("full_fall_edges", n, 242);
        check("full_fall_busy_low", int'(busy), 0);
        cyc();
        all_ok = 1;
        for (int i = 0; i < 16; i++) begin cyc(); if (q !== 1'b0) all_ok = 0; end
        check("off_q_const_low", int'(all_ok), 1);

        // duty at level 5
        blink = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (level != 4'd5 && n < 200);
        check("reach_level5", int'(level), 5);
        hi = 0;
        for (int i = 0; i < 16; i++) begin cyc(); hi += int'(q); end
        check("duty_level5", hi, 5);
        blink = 1'b0;
        n = 0;
        do begin cyc(); n++; end while ((busy || level != 4'd0) && n < 400);
        check("duty_return_off", int'(level), 0);
        cyc(); cyc();

        // reversal after 100 cycles high
        blink = 1'b1;
        peak = 0;
        for (int i = 0; i < 100; i++) begin cyc(); if (int'(level) > peak) peak = int'(level); end
        blink = 1'b0;
        n = 0;
        do begin
            cyc(); n++;
            if (int'(level) > peak) peak = int'(level);
        end while (busy && n < 400);
        check("reversal_peak", peak, 6);
        check("reversal_return_edges", n, 98);
        check("reversal_end_level", int'(level), 0);

        // randomized blink with occasional resets
        for (int s = 0; s < 40; s++) begin
            blink = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 300);
            if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) cyc();
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_level", int'(level), 0);
                cyc(); cyc();
                rst_n = 1'b1;
            end
        end
        chk_en = 0;

        // small parameters: pwm_bits=2, step_cycles=1
        cyc();
        rst2_n = 1'b1;
        cyc();
        blink2 = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!busy2 && n < 10);
        check("p2_busy_edges", n, 2);
        n = 0;
        do begin cyc(); n++; end while (level2 != 2'd3 && n < 20);
        check("p2_full_rise_edges", n, 3);
        check("p2_busy_low", int'(busy2), 0);
        blink2 = 1'b0;
        n = 0;
        do begin cyc(); n++; end while ((busy2 || level2 != 2'd0) && n < 20);
        check("p2_full_fall_edges", n, 5);
        cyc();
        blink2 = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (level2 != 2'd2 && n < 20);
        check("p2_reach_level2", int'(level2), 2);
        rst2_n = 1'b0;
        #1;
        check("p2_async_rst_level", int'(level2), 0);
        check("p2_async_rst_q", int'(q2), 0);
        check("p2_async_rst_busy", int'(busy2), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
